// File: rtl/rsbus_d2r_mgr_gnt.sv
// +--------------------------------------------------------------------------+
// | Module      : rsbus_d2r_mgr_gnt                                          |
// | Description : d2r grant stage. Takes one queued request per handshake    |
// |               from the FIFO bank. Checks it against a receive-buffer     |
// |               credit pool, then issues one grant word towards the ring.  |
// |               Credits come back from the receive buffer as slots drain.  |
// | Option      : RSBUS_D2R_GNT_STATS_EN adds per-priority grant counters    |
// |               and a stall-cycle counter.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module rsbus_d2r_mgr_gnt #(
  parameter  int CREDITS = 64,
  parameter  int HOLDOFF = 4,
  localparam int CW      = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_stb,
  input  logic [1:0]    i_prior,
  input  logic [3:0]    i_req,
  input  logic [3:0]    i_rid,
  output logic          i_ack,
  output logic          g_stb,
  output logic [1:0]    g_prior,
  output logic [3:0]    g_rid,
  output logic [3:0]    g_cnt,
  input  logic          g_rdy,
  input  logic          c_stb,
  input  logic [3:0]    c_cnt,
  output logic [CW-1:0] credits,
  output logic          err
`ifdef RSBUS_D2R_GNT_STATS_EN
  ,
  output logic [15:0]   st_gnt0,
  output logic [15:0]   st_gnt1,
  output logic [15:0]   st_gnt2,
  output logic [15:0]   st_gnt3,
  output logic [15:0]   st_stall
`endif
);

  // Credit arithmetic width: wide enough for a 4-bit operand and a carry,
  // so a negative intermediate result is never aliased.
  localparam int              c_aw          = ((CW > 4) ? CW : 4) + 2;
  localparam logic [c_aw-1:0] c_credits_max = c_aw'(CREDITS);
  localparam logic [3:0]      c_holdoff     = 4'(HOLDOFF);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_GRANT = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_hold;
  logic [3:0]      w_hold_nxt;
  logic            w_capture;
  logic            w_grant_set;
  logic            w_fire;
  logic [c_aw-1:0] w_ret;
  logic [c_aw-1:0] w_avail;
  logic [c_aw-1:0] w_need;
  logic [c_aw-1:0] w_cons;
  logic [c_aw-1:0] w_sum;
  logic [CW-1:0]   w_credits_nxt;
  logic            w_over_ret;
  logic            w_req_over;

  assign w_fire  = g_stb && g_rdy;
  assign w_ret   = c_stb ? c_aw'(c_cnt) : '0;
  // Available credits include a return that lands in this same cycle.
  assign w_avail = c_aw'(credits) + w_ret;
  assign w_need  = c_aw'(g_cnt);
  assign w_cons  = w_fire ? w_need : '0;
  // An over-sized request is granted anyway and drains the pool to zero.
  assign w_sum   = (w_avail >= w_cons) ? (w_avail - w_cons) : '0;
  assign w_over_ret    = (w_sum > c_credits_max);
  assign w_credits_nxt = w_over_ret ? CW'(CREDITS) : w_sum[CW-1:0];
  assign w_req_over    = (c_aw'(i_req) > c_credits_max);

  // State and holdoff counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hold  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  // Next-state logic: capture, credit check, grant handshake, refresh holdoff.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_capture   = 1'b0;
    w_grant_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_stb && (r_hold == 4'd0)) begin
          w_capture   = 1'b1;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((w_avail >= w_need) || (w_need > c_credits_max)) begin
          w_grant_set = 1'b1;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_fire) begin
          w_hold_nxt  = c_holdoff;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        // Leaving on the cycle the count reaches zero keeps the grant
        // period at 3 + HOLDOFF cycles.
        if (r_hold <= 4'd1) begin
          w_hold_nxt  = 4'd0;
          w_state_nxt = S_IDLE;
        end else begin
          w_hold_nxt  = r_hold - 4'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant word, grant strobe and head-consumed acknowledge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_ack   <= 1'b0;
      g_stb   <= 1'b0;
      g_prior <= 2'd0;
      g_rid   <= 4'd0;
      g_cnt   <= 4'd0;
    end else begin
      i_ack <= w_fire;
      if (w_capture) begin
        g_prior <= i_prior;
        g_rid   <= i_rid;
        g_cnt   <= i_req;
      end
      if (w_grant_set) begin
        g_stb <= 1'b1;
      end else if (w_fire) begin
        g_stb <= 1'b0;
      end
    end
  end

  // Credit pool update and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credits <= CW'(CREDITS);
      err     <= 1'b0;
    end else begin
      credits <= w_credits_nxt;
      if (w_over_ret || (w_capture && w_req_over)) begin
        err <= 1'b1;
      end
    end
  end

`ifdef RSBUS_D2R_GNT_STATS_EN
  // Per-priority fired-grant counters and CHECK stall counter, wrapping at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_gnt0  <= 16'd0;
      st_gnt1  <= 16'd0;
      st_gnt2  <= 16'd0;
      st_gnt3  <= 16'd0;
      st_stall <= 16'd0;
    end else begin
      if (w_fire) begin
        case (g_prior)
          2'd0:    st_gnt0 <= st_gnt0 + 16'd1;
          2'd1:    st_gnt1 <= st_gnt1 + 16'd1;
          2'd2:    st_gnt2 <= st_gnt2 + 16'd1;
          default: st_gnt3 <= st_gnt3 + 16'd1;
        endcase
      end
      if (r_state == S_CHECK) begin
        st_stall <= st_stall + 16'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rsbus_d2r_mgr_gnt.sv
// +--------------------------------------------------------------------------+
// | Module      : tb_rsbus_d2r_mgr_gnt                                       |
// | Description : Scoreboard bench for the d2r grant stage. Expected grant   |
// |               words are queued as requests enter the emulated FIFO bank. |
// |               A negedge monitor pops them on each grant handshake and    |
// |               tracks the credit pool with plain integer arithmetic.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_rsbus_d2r_mgr_gnt;

  localparam int CREDITS = 64;
  localparam int HOLDOFF = 4;
  localparam int CW      = $clog2(CREDITS + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          i_stb;
  logic [1:0]    i_prior;
  logic [3:0]    i_req;
  logic [3:0]    i_rid;
  logic          i_ack;
  logic          g_stb;
  logic [1:0]    g_prior;
  logic [3:0]    g_rid;
  logic [3:0]    g_cnt;
  logic          g_rdy;
  logic          c_stb;
  logic [3:0]    c_cnt;
  logic [CW-1:0] credits;
  logic          err;

  rsbus_d2r_mgr_gnt #(.CREDITS(CREDITS), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .rst(rst),
    .i_stb(i_stb), .i_prior(i_prior), .i_req(i_req), .i_rid(i_rid), .i_ack(i_ack),
    .g_stb(g_stb), .g_prior(g_prior), .g_rid(g_rid), .g_cnt(g_cnt), .g_rdy(g_rdy),
    .c_stb(c_stb), .c_cnt(c_cnt), .credits(credits), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int p; int r; int id; } req_t;

  int   nchk = 0;
  int   nerr = 0;
  int   cyc  = 0;
  req_t fifo[$];
  req_t exp_q[$];
  int   fire_cyc[$];
  int   rise_cyc[$];
  int   m_credits = CREDITS;
  int   m_err     = 0;
  int   prev_fire = 0;
  int   prev_gstb = 0;
  int   last_fire = 0;
  int   have_last = 0;
  int   ack_cnt   = 0;
  int   ack_done  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    nchk++;
    if (act != expv) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: checks per-cycle outputs, pops the scoreboard on each grant
  // handshake and advances the credit-pool reference.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_g_stb", int'(g_stb), 0);
      chk("rst_i_ack", int'(i_ack), 0);
      chk("rst_credits", int'(credits), CREDITS);
      chk("rst_err", int'(err), 0);
      chk("rst_g_word", int'({g_prior, g_rid, g_cnt}), 0);
      m_credits = CREDITS;
      m_err     = 0;
      prev_fire = 0;
      prev_gstb = 0;
      have_last = 0;
    end else begin
      int   tot;
      int   cons;
      int   fire;
      req_t e;
      chk("i_ack", int'(i_ack), prev_fire);
      chk("credits", int'(credits), m_credits);
      chk("err", int'(err), m_err);
      if (g_stb && (prev_gstb == 0)) rise_cyc.push_back(cyc);
      prev_gstb = int'(g_stb);
      fire = (g_stb && g_rdy) ? 1 : 0;
      cons = 0;
      if (fire != 0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("g_prior", int'(g_prior), e.p);
          chk("g_rid", int'(g_rid), e.id);
          chk("g_cnt", int'(g_cnt), e.r);
          cons = e.r;
        end
        if (have_last != 0) chk("grant_gap_min", ((cyc - last_fire) >= 3 + HOLDOFF) ? 1 : 0, 1);
        fire_cyc.push_back(cyc);
        last_fire = cyc;
        have_last = 1;
      end
      tot = m_credits - cons + (c_stb ? int'(c_cnt) : 0);
      if (tot > CREDITS) begin
        tot   = CREDITS;
        m_err = 1;
      end
      if (tot < 0) tot = 0;
      m_credits = tot;
      if (i_ack) ack_cnt++;
      prev_fire = fire;
    end
  end

  task automatic drive_head();
    if (fifo.size() > 0) begin
      i_stb   = 1'b1;
      i_prior = 2'(fifo[0].p);
      i_req   = 4'(fifo[0].r);
      i_rid   = 4'(fifo[0].id);
    end else begin
      i_stb   = 1'b0;
    end
  endtask

  // Advance one clock; the emulated FIFO bank pops its head on each ack.
  task automatic step();
    @(posedge clk);
    #1;
    while (ack_done < ack_cnt) begin
      ack_done++;
      if (fifo.size() > 0) fifo.delete(0);
    end
    drive_head();
  endtask

  task automatic push_req(input int p, input int r, input int id);
    req_t t;
    t.p = p; t.r = r; t.id = id;
    fifo.push_back(t);
    exp_q.push_back(t);
    drive_head();
  endtask

  task automatic wait_fires(input string name, input int n, input int budget);
    int start = fire_cyc.size();
    int k = 0;
    while ((fire_cyc.size() < start + n) && (k < budget)) begin
      step();
      k++;
    end
    chk(name, fire_cyc.size() - start, n);
  endtask

  task automatic wait_gstb(input string name, input int budget);
    int k = 0;
    while (!g_stb && (k < budget)) begin
      step();
      k++;
    end
    chk(name, int'(g_stb), 1);
  endtask

  task automatic rand_return();
    int room = CREDITS - m_credits;
    if ((room > 0) && ($urandom_range(0, 2) == 0)) begin
      c_stb = 1'b1;
      c_cnt = 4'($urandom_range(1, (room > 15) ? 15 : room));
    end else begin
      c_stb = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
    $fatal(1);
  end

  initial begin
    int s;
    int a0;
    rst = 1'b1; i_stb = 1'b0; i_prior = 2'd0; i_req = 4'd0; i_rid = 4'd0;
    g_rdy = 1'b0; c_stb = 1'b0; c_cnt = 4'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single request: latency 2, credits 64 -> 61, one ack.
    a0 = ack_cnt;
    g_rdy = 1'b1;
    push_req(2, 3, 5);
    s = cyc;
    wait_fires("t1_fire", 1, 20);
    if (rise_cyc.size() > 0) chk("t1_latency", rise_cyc[rise_cyc.size()-1] - s, 2);
    chk("t1_credits", int'(credits), 61);
    repeat (8) step();
    chk("t1_acks", ack_cnt - a0, 1);

    // Back-to-back heads: grants exactly 3+HOLDOFF apart, one ack each.
    a0 = ack_cnt;
    push_req(1, 2, 7);
    push_req(3, 4, 9);
    wait_fires("t2_fire", 2, 40);
    if (fire_cyc.size() >= 2)
      chk("t2_gap", fire_cyc[fire_cyc.size()-1] - fire_cyc[fire_cyc.size()-2], 3 + HOLDOFF);
    repeat (8) step();
    chk("t2_acks", ack_cnt - a0, 2);
    chk("t2_credits", int'(credits), 55);

    // Zero-length request: granted with g_cnt=0, pool unchanged.
    push_req(0, 0, 1);
    wait_fires("t2b_fire", 1, 20);
    repeat (8) step();
    chk("t2b_credits", int'(credits), 55);

    // Drain the pool to 2, then starve a 5-slot request.
    push_req(0, 15, 2); push_req(1, 15, 3); push_req(2, 15, 4); push_req(3, 8, 6);
    wait_fires("t3_drain", 4, 60);
    repeat (8) step();
    chk("t3_pool", int'(credits), 2);
    push_req(0, 5, 3);
    repeat (12) step();
    chk("t3_starved_gstb", int'(g_stb), 0);
    chk("t3_starved_credits", int'(credits), 2);
    c_stb = 1'b1; c_cnt = 4'd3;
    step();
    c_stb = 1'b0;
    chk("t3_gstb_after_return", int'(g_stb), 1);
    chk("t3_credits_after_return", int'(credits), 5);
    step();
    chk("t3_credits_after_grant", int'(credits), 0);

    // Simultaneous consume 4 and return 6 at credits 10 -> 12.
    c_stb = 1'b1; c_cnt = 4'd10;
    g_rdy = 1'b0;
    step();
    c_stb = 1'b0;
    repeat (8) step();
    chk("t4_pool", int'(credits), 10);
    push_req(1, 4, 2);
    wait_gstb("t4_gstb", 10);
    g_rdy = 1'b1; c_stb = 1'b1; c_cnt = 4'd6;
    step();
    g_rdy = 1'b0; c_stb = 1'b0;
    chk("t4_credits", int'(credits), 12);
    repeat (8) step();

    // Refill to the top, then over-return by one: clamp and sticky err.
    c_stb = 1'b1; c_cnt = 4'd15; step(); step(); step();
    c_cnt = 4'd7; step();
    c_stb = 1'b0;
    chk("t5_full", int'(credits), 64);
    chk("t5_err_clear", int'(err), 0);
    c_stb = 1'b1; c_cnt = 4'd1;
    step();
    c_stb = 1'b0;
    chk("t5_clamp", int'(credits), 64);
    chk("t5_err_set", int'(err), 1);
    repeat (5) step();
    chk("t5_err_sticky", int'(err), 1);

    // Reset while a grant is held, then a normal grant afterwards.
    push_req(2, 7, 4);
    wait_gstb("t6_gstb", 10);
    rst = 1'b1;
    fifo.delete();
    exp_q.delete();
    drive_head();
    #1;
    chk("t6_gstb_reset", int'(g_stb), 0);
    chk("t6_credits_reset", int'(credits), 64);
    step();
    rst = 1'b0;
    ack_done = ack_cnt;
    g_rdy = 1'b1;
    push_req(3, 6, 11);
    s = cyc;
    wait_fires("t6_fire", 1, 20);
    if (rise_cyc.size() > 0) chk("t6_latency", rise_cyc[rise_cyc.size()-1] - s, 2);
    chk("t6_credits", int'(credits), 58);

    // Randomised traffic: backpressure, bounded returns, starvation.
    for (int i = 0; i < 400; i++) begin
      if ((fifo.size() < 4) && ($urandom_range(0, 3) == 0))
        push_req(int'($urandom_range(0, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      g_rdy = ($urandom_range(0, 3) != 0);
      rand_return();
      step();
    end

    // Drain every outstanding request.
    g_rdy = 1'b1;
    for (int k = 0; (k < 3000) && ((fifo.size() > 0) || (exp_q.size() > 0)); k++) begin
      rand_return();
      step();
    end
    c_stb = 1'b0;
    step();
    chk("drain_scoreboard", exp_q.size(), 0);
    chk("drain_fifo", fifo.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

`default_nettype wire
